// File: rtl/countdown_timer_pkg.sv
// Shared types and constants for the loadable countdown timer.
package countdown_timer_pkg;

    typedef enum logic {IDLE, RUN} state_t;

    localparam int unsigned CT_WIDTH_DEFAULT = 4;

endpackage

// File: rtl/countdown_timer_if.sv
// Load handshake bundle: requester drives value/mode, timer answers with ready.
interface countdown_timer_if
    import countdown_timer_pkg::*;
#(
    parameter int unsigned WIDTH = CT_WIDTH_DEFAULT
);

    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] load_value;
    logic             periodic;

    modport master (
        output load_valid,
        output load_value,
        output periodic,
        input  load_ready
    );

    modport slave (
        input  load_valid,
        input  load_value,
        input  periodic,
        output load_ready
    );

endinterface

// File: rtl/countdown_timer.sv
// Loadable down-counter with one-shot/periodic modes and a one-cycle done pulse.
module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter int unsigned WIDTH = CT_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             abort,
    countdown_timer_if.slave ld,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             mode_q, mode_d;
    logic             done_q, done_d;
    logic             busy_q, ready_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            count_q  <= '0;
            reload_q <= '0;
            mode_q   <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            mode_q   <= mode_d;
            done_q   <= done_d;
            // busy/ready decoded from next state so they stay registered outputs
            busy_q   <= (state_d == RUN);
            ready_q  <= (state_d == IDLE);
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        mode_d   = mode_q;
        done_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (ld.load_valid) begin
                    count_d  = ld.load_value;
                    reload_d = ld.load_value;
                    mode_d   = ld.periodic;
                    if (ld.load_value != '0) begin
                        state_d = RUN;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                    count_d = '0;
                end else if (en) begin
                    if (count_q > WIDTH'(1)) begin
                        count_d = count_q - WIDTH'(1);
                    end else if (mode_q) begin
                        count_d = reload_q;
                        done_d  = 1'b1;
                    end else begin
                        count_d = '0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign count         = count_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign ld.load_ready = ready_q;

endmodule
